// File: rtl/mmio_console_pkg.sv
// Shared definitions for the MMIO console/halt responder: register map, STATUS layout,
// access sizes and the big-endian lane helpers used by both the read and push paths.
package mmio_console_pkg;

  localparam logic [31:0] BASE_DEFAULT  = 32'h0000_FF00;
  localparam int unsigned DEPTH_DEFAULT = 8;

  // Word index within the 16-byte window (addr bits [3:2] in LSB-0 numbering)
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_HALT   = 2'd2;
  localparam logic [1:0] REG_CYCLES = 2'd3;

  // STATUS bit positions in LSB-0 numbering (big-endian bit 31 is bit 0 here)
  localparam int unsigned ST_EMPTY     = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_OVF       = 2;
  localparam int unsigned ST_COUNT_LSB = 3;
  localparam int unsigned ST_COUNT_W   = 5;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } size_e;

  function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

  function automatic logic [31:0] read_lane(input logic [31:0] word, input size_e sz,
                                            input logic [1:0] lane, input logic sext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = pick_byte(word, lane);
    h = lane[1] ? word[15:0] : word[31:16];
    case (sz)
      SZ_BYTE: r = {{24{sext & b[7]}}, b};
      SZ_HALF: r = {{16{sext & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Byte pushed into the TX FIFO for a store of the given size
  function automatic logic [7:0] tx_byte(input logic [31:0] word, input size_e sz,
                                         input logic [1:0] lane);
    logic [7:0] b;
    case (sz)
      SZ_BYTE: b = pick_byte(word, lane);
      SZ_HALF: b = lane[1] ? word[7:0] : word[23:16];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mmio_console_fifo.sv
// Synchronous byte FIFO with registered storage; rd_data is the current head entry.
module mmio_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             wr_data,
  output logic [7:0]             rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // A pop frees a slot for a same-cycle push even when full
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/mmio_console.sv
// Memory-mapped console/halt responder: TX byte FIFO, W1C overflow flag, sticky HALT
// register with exit code, and a free-running cycle counter behind a 16-byte window.
module mmio_console
  import mmio_console_pkg::*;
#(
  parameter logic [31:0] BASE  = BASE_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [0:31] addr,
  input  logic [0:31] data_in,
  input  logic        write_enable,
  input  logic        mem_byte,
  input  logic        mem_half_word,
  input  logic        sign_extend,
  output logic [0:31] data_out,
  output logic        hit,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        halt,
  output logic [0:31] halt_code
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]   a, wdata, reg_word, status;
  logic [1:0]    reg_sel, lane;
  size_e         size;
  logic          wr_hit, push, pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          overflow_q, overflow_d, halt_q, halt_d;
  logic [31:0]   halt_code_q, halt_code_d, cycles_q, cycles_d;

  // Decode; big-endian ports are re-viewed LSB-0 so numeric values are unchanged
  always_comb begin
    a       = addr;
    wdata   = data_in;
    reg_sel = a[3:2];
    lane    = a[1:0];
    size    = mem_byte ? SZ_BYTE : (mem_half_word ? SZ_HALF : SZ_WORD);
    hit     = (a[31:4] == BASE[31:4]);
    wr_hit  = write_enable && hit;
    push    = wr_hit && (reg_sel == REG_TXDATA);
    pop     = !fifo_empty && tx_ready;
  end

  mmio_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (tx_byte(wdata, size, lane)),
    .rd_data (tx_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // A dropped push on the same edge as a W1C clear leaves overflow set
  always_comb begin
    overflow_d  = overflow_q;
    halt_d      = halt_q;
    halt_code_d = halt_code_q;
    cycles_d    = cycles_q + 32'd1;
    if (push && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end else if (wr_hit && (reg_sel == REG_STATUS) && (size == SZ_WORD) && wdata[ST_OVF]) begin
      overflow_d = 1'b0;
    end
    if (wr_hit && (reg_sel == REG_HALT) && (size == SZ_WORD) && !halt_q) begin
      halt_d      = 1'b1;
      halt_code_d = wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      halt_q      <= 1'b0;
      halt_code_q <= '0;
      cycles_q    <= '0;
    end else begin
      overflow_q  <= overflow_d;
      halt_q      <= halt_d;
      halt_code_q <= halt_code_d;
      cycles_q    <= cycles_d;
    end
  end

  always_comb begin
    status                                = '0;
    status[ST_EMPTY]                      = fifo_empty;
    status[ST_FULL]                       = fifo_full;
    status[ST_OVF]                        = overflow_q;
    status[ST_COUNT_LSB +: ST_COUNT_W]    = ST_COUNT_W'(fifo_count);
    case (reg_sel)
      REG_STATUS: reg_word = status;
      REG_HALT:   reg_word = {31'b0, halt_q};
      REG_CYCLES: reg_word = cycles_q;
      default:    reg_word = '0;
    endcase
    data_out = hit ? read_lane(reg_word, size, lane, sign_extend) : '0;
  end

  assign tx_valid  = !fifo_empty;
  assign halt      = halt_q;
  assign halt_code = halt_code_q;

endmodule

// File: tb/tb_mmio_console.sv
// Self-checking bench for mmio_console: directed scenarios plus a randomized run against
// a queue-based reference model of the console registers.
module tb_mmio_console;
  localparam logic [31:0] BASE  = 32'h0000_FF00;
  localparam int          DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] addr, din, dout, hcode;
  logic        we, mb, mh, sx, hit, txv, txr, halt;
  logic [7:0]  txd;

  int total = 0;
  int bad   = 0;

  logic [7:0]  m_q[$];
  bit          m_ovf, m_halt;
  logic [31:0] m_code, m_cyc;

  mmio_console #(.BASE(BASE), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .addr(addr), .data_in(din), .write_enable(we),
    .mem_byte(mb), .mem_half_word(mh), .sign_extend(sx), .data_out(dout), .hit(hit),
    .tx_data(txd), .tx_valid(txv), .tx_ready(txr), .halt(halt), .halt_code(hcode)
  );

  always #5 clock = ~clock;

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input bit w,
                       input int sz, input bit s);
    addr = a; din = d; we = w; mb = (sz == 1); mh = (sz == 2); sx = s;
    #1;
  endtask

  function automatic logic [31:0] exp_read(input logic [31:0] a, input int sz, input bit s);
    logic [31:0] w, v;
    int n, sh;
    n = m_q.size();
    if (a[31:4] != BASE[31:4]) return 32'h0;
    case (a[3:2])
      2'd1:    w = 32'(n * 8 + (m_ovf ? 4 : 0) + (n == DEPTH ? 2 : 0) + (n == 0 ? 1 : 0));
      2'd2:    w = m_halt ? 32'd1 : 32'd0;
      2'd3:    w = m_cyc;
      default: w = 32'h0;
    endcase
    if (sz == 1) begin
      sh = 8 * (3 - int'(a[1:0]));
      v = (w >> sh) & 32'hFF;
      if (s && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      sh = a[1] ? 0 : 16;
      v = (w >> sh) & 32'hFFFF;
      if (s && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  // Advance the model by one clock using the currently driven inputs, then clock the DUT
  task automatic cycle();
    bit          h, pop_ok, wr;
    logic [7:0]  pb;
    logic [31:0] half;
    int          sh;
    h      = (addr[31:4] == BASE[31:4]);
    pop_ok = txr && (m_q.size() > 0);
    wr     = we && h;
    if (mb) begin
      sh = 8 * (3 - int'(addr[1:0]));
      pb = 8'((din >> sh) & 32'hFF);
    end else if (mh) begin
      half = addr[1] ? (din & 32'hFFFF) : (din >> 16);
      pb   = 8'(half & 32'hFF);
    end else begin
      pb = din[7:0];
    end
    if (pop_ok) void'(m_q.pop_front());
    if (wr && addr[3:2] == 2'd0) begin
      if (m_q.size() < DEPTH) m_q.push_back(pb);
      else m_ovf = 1'b1;
    end else if (wr && addr[3:2] == 2'd1 && !mb && !mh && din[2]) begin
      m_ovf = 1'b0;
    end
    if (wr && addr[3:2] == 2'd2 && !mb && !mh && !m_halt) begin
      m_halt = 1'b1;
      m_code = din;
    end
    m_cyc = m_cyc + 32'd1;
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_q.delete(); m_ovf = 0; m_halt = 0; m_code = 0; m_cyc = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; txr = 1'b0;
    drive(32'h0, 32'h0, 0, 4, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    total++; if (txv !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", txv); end
    total++; if (txd !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", txd); end
    total++; if (halt !== 1'b0) begin bad++; $display("FAIL reset_halt: got %b want 0", halt); end
    total++; if (hcode !== 32'h0) begin bad++; $display("FAIL reset_code: got %h want 0", hcode); end
    drive(BASE + 4, 32'h0, 0, 4, 0);
    total++; if (dout !== 32'h1) begin bad++; $display("FAIL reset_status: got %h want 00000001", dout); end
  endtask

  task automatic test_single_tx();
    txr = 1'b1;
    drive(BASE, 32'h0000_0041, 1, 4, 0);
    cycle();
    drive(BASE, 32'h0, 0, 4, 0);
    total++; if (txv !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", txv); end
    total++; if (txd !== 8'h41) begin bad++; $display("FAIL single_data: got %h want 41", txd); end
    cycle();
    total++; if (txv !== 1'b0) begin bad++; $display("FAIL single_drained: got %b want 0", txv); end
  endtask

  task automatic test_overflow();
    txr = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(BASE + 1, 32'(8'h11 + i) << 16, 1, 1, 0);
      cycle();
    end
    drive(BASE + 4, 32'h0, 0, 4, 0);
    total++; if (dout !== 32'h46) begin bad++; $display("FAIL ovf_status: got %h want 00000046", dout); end
    txr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (txv !== 1'b1 || txd !== 8'(8'h11 + i)) begin
        bad++; $display("FAIL ovf_drain%0d: got v=%b d=%h want v=1 d=%h", i, txv, txd, 8'(8'h11 + i));
      end
      cycle();
    end
    total++; if (txv !== 1'b0) begin bad++; $display("FAIL ovf_empty: got %b want 0", txv); end
    drive(BASE + 4, 32'h0000_0004, 1, 4, 0);
    cycle();
    drive(BASE + 4, 32'h0, 0, 4, 0);
    total++; if (dout !== 32'h1) begin bad++; $display("FAIL ovf_clear: got %h want 00000001", dout); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp8 [8];
    exp8 = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h30};
    txr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(BASE, 32'h20 + 32'(i), 1, 4, 0);
      cycle();
    end
    txr = 1'b1;
    drive(BASE, 32'h30, 1, 4, 0);
    cycle();
    txr = 1'b0;
    drive(BASE + 4, 32'h0, 0, 4, 0);
    total++; if (dout !== 32'h42) begin bad++; $display("FAIL fpp_status: got %h want 00000042", dout); end
    txr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (txv !== 1'b1 || txd !== exp8[i]) begin
        bad++; $display("FAIL fpp_drain%0d: got v=%b d=%h want v=1 d=%h", i, txv, txd, exp8[i]);
      end
      cycle();
    end
  endtask

  task automatic test_halt();
    drive(BASE + 8, 32'h0000_1234, 1, 1, 0);
    cycle();
    total++; if (halt !== 1'b0) begin bad++; $display("FAIL halt_byte_ignored: got %b want 0", halt); end
    drive(BASE + 8, 32'hDEAD_BEEF, 1, 4, 0);
    cycle();
    total++; if (halt !== 1'b1) begin bad++; $display("FAIL halt_set: got %b want 1", halt); end
    total++; if (hcode !== 32'hDEAD_BEEF) begin bad++; $display("FAIL halt_code: got %h want deadbeef", hcode); end
    drive(BASE + 8, 32'h1, 1, 4, 0);
    cycle();
    total++; if (hcode !== 32'hDEAD_BEEF) begin bad++; $display("FAIL halt_sticky: got %h want deadbeef", hcode); end
    drive(BASE + 11, 32'h0, 0, 1, 1);
    total++; if (dout !== 32'h1) begin bad++; $display("FAIL halt_read: got %h want 00000001", dout); end
  endtask

  task automatic test_reads();
    txr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(BASE, 32'h50 + 32'(i), 1, 4, 0);
      cycle();
    end
    drive(BASE + 4, 32'h0, 0, 1, 1);
    total++; if (dout !== 32'h0) begin bad++; $display("FAIL rd_byte0: got %h want 0", dout); end
    drive(BASE + 6, 32'h0, 0, 2, 1);
    total++; if (dout !== 32'h42) begin bad++; $display("FAIL rd_half: got %h want 00000042", dout); end
    drive(BASE + 16, 32'h99, 1, 4, 0);
    total++; if (hit !== 1'b0 || dout !== 32'h0) begin bad++; $display("FAIL rd_miss: got hit=%b d=%h want hit=0 d=0", hit, dout); end
    cycle();
    drive(BASE + 4, 32'h0, 0, 4, 0);
    total++; if (dout !== 32'h42) begin bad++; $display("FAIL miss_no_push: got %h want 00000042", dout); end
    drive(BASE + 14, 32'h0, 0, 2, 1);
    total++; if (dout !== exp_read(BASE + 14, 2, 1)) begin bad++; $display("FAIL rd_cycles_half: got %h want %h", dout, exp_read(BASE + 14, 2, 1)); end
  endtask

  task automatic test_random();
    logic [31:0] a, e;
    int          szs [3];
    szs = '{1, 2, 4};
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) a = $urandom;
      else a = BASE | 32'($urandom_range(0, 15));
      drive(a, $urandom, 1'($urandom_range(0, 1)), szs[$urandom_range(0, 2)], 1'($urandom_range(0, 1)));
      txr = (n < 200) ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1));
      #1;
      e = exp_read(addr, mb ? 1 : (mh ? 2 : 4), sx);
      total++; if (dout !== e) begin bad++; $display("FAIL rnd_read%0d: got %h want %h", n, dout, e); end
      total++; if (hit !== (addr[31:4] == BASE[31:4])) begin bad++; $display("FAIL rnd_hit%0d: got %b", n, hit); end
      total++; if (txv !== (m_q.size() > 0)) begin bad++; $display("FAIL rnd_valid%0d: got %b want %b", n, txv, m_q.size() > 0); end
      if (m_q.size() > 0) begin
        total++; if (txd !== m_q[0]) begin bad++; $display("FAIL rnd_data%0d: got %h want %h", n, txd, m_q[0]); end
      end
      total++; if (halt !== m_halt || hcode !== m_code) begin bad++; $display("FAIL rnd_halt%0d: got %b/%h want %b/%h", n, halt, hcode, m_halt, m_code); end
      cycle();
    end
  endtask

  task automatic test_reset_mid_drain();
    txr = 1'b1;
    drive(BASE + 4, 32'h0, 0, 4, 0);
    repeat (DEPTH + 1) cycle();
    txr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(BASE, 32'h60 + 32'(i), 1, 4, 0);
      cycle();
    end
    drive(BASE + 12, 32'h0, 0, 4, 0);
    txr = 1'b1;
    cycle();
    total++; if (txv !== 1'b1 || txd !== 8'h61) begin bad++; $display("FAIL mid_before: got v=%b d=%h want v=1 d=61", txv, txd); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (txv !== 1'b0 || txd !== 8'h00) begin bad++; $display("FAIL mid_async: got v=%b d=%h want v=0 d=00", txv, txd); end
    total++; if (halt !== 1'b0) begin bad++; $display("FAIL mid_halt: got %b want 0", halt); end
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    total++; if (dout !== 32'h0) begin bad++; $display("FAIL cyc0: got %h want 0", dout); end
    cycle();
    total++; if (dout !== 32'h1) begin bad++; $display("FAIL cyc1: got %h want 1", dout); end
    cycle();
    total++; if (dout !== 32'h2) begin bad++; $display("FAIL cyc2: got %h want 2", dout); end
    total++; if (txv !== 1'b0) begin bad++; $display("FAIL mid_empty: got %b want 0", txv); end
  endtask

  initial begin
    test_reset();
    test_single_tx();
    test_overflow();
    test_full_push_pop();
    test_halt();
    test_reads();
    test_random();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
